wc_tile_ctrl: RTL and testbench
===============================

WC_TILE_CTRL -- requirements
Module: wc_tile_ctrl

Interface
REQ-001 Parameter DW, default 10, element width in bits (two's complement).
REQ-002 Parameter NIN, default 9, input elements per tile.
REQ-003 Parameter NOUT, default 5, output elements per tile.
REQ-004 Parameter LAT, default 6, datapath result latency in cycles (LAT >= 1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle job launch request.
REQ-008 cfg_ntiles  input  8  tiles in the job; sampled only when start is accepted.
REQ-009 in_valid  input  1  upstream tile valid.
REQ-010 in_ready  output  1  controller accepts a tile this cycle.
REQ-011 in_data  input  DW*NIN  packed input tile; element 0 in the MSBs.
REQ-012 dp_d  output  DW*NIN  registered operand bus to the Winograd datapath D port.
REQ-013 dp_z  input  DW*NOUT  datapath result bus, from the datapath Z port.
REQ-014 out_valid  output  1  result tile valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_data  output  DW*NOUT  captured result tile.
REQ-017 out_last  output  1  high with out_valid on the job's final tile.
REQ-018 busy  output  1  high from start acceptance until done.
REQ-019 done  output  1  single-cycle job-complete pulse.
REQ-020 tile_cnt  output  8  number of result handshakes completed in the current job.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, WAIT, EMIT, FIN.
REQ-022 IDLE: start=1 latches cfg_ntiles, clears tile_cnt, and sets busy; next state is FETCH if cfg_ntiles!=0, else FIN.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 in_ready SHALL equal 1 only in FETCH; an accept occurs when in_valid&in_ready, and the next state is WAIT.
REQ-025 On accept edge E0, dp_d SHALL load in_data; dp_d SHALL hold that value until the next accept.
REQ-026 WAIT counts LAT cycles; at edge E0+LAT the controller captures dp_z into out_data and enters EMIT, so out_valid is first high in the cycle after E0+LAT.
REQ-027 EMIT: out_valid=1; out_data and out_last SHALL stay stable until out_valid&out_ready.
REQ-028 On the output handshake, tile_cnt increments (mod 256); next state is FETCH if tile_cnt+1 < latched ntiles, else FIN.
REQ-029 out_last SHALL be 1 in EMIT iff tile_cnt == latched ntiles-1.
REQ-030 FIN SHALL last one cycle with done=1; busy=0 from the following cycle; next state is IDLE.
REQ-031 The controller SHALL never have more than one tile in flight: no accept occurs in WAIT or EMIT.
REQ-032 out_ready may be high before out_valid; the handshake occurs in the first EMIT cycle, giving minimum tile period LAT+2 cycles.
REQ-033 dp_z SHALL be sampled only at edge E0+LAT; values at other times have no effect.

Reset
REQ-034 While rst=1 at a rising edge: state<=IDLE; dp_d, out_data, tile_cnt<=0; in_ready, out_valid, out_last, busy, done<=0.
REQ-035 A reset mid-job (any state) SHALL discard the in-flight tile with no done pulse; the next start after reset SHALL run normally.
REQ-036 rst SHALL take priority over start and over all handshakes in the same cycle.

Verification
REQ-037 Reset: hold rst 2 cycles with in_valid=1 and start=1 -> all outputs 0, in_ready 0, state IDLE.
REQ-038 Single tile: start with cfg_ntiles=1, in_data = elements [2,-10,3,4,-13,-18,-16,-28,-11], datapath stub returns Z=[160,-380,-502,93,-120] -> dp_d equals the input from E0; out_valid rises at E0+6 with out_data = Z and out_last=1; done pulses one cycle after the handshake; tile_cnt=1.
REQ-039 Backpressure: cfg_ntiles=3, out_ready low for 4 cycles on tile 2 -> out_data stable, in_ready=0 throughout, out_last only on tile 3, tile_cnt ends at 3, exactly one done pulse.
REQ-040 Zero length: start with cfg_ntiles=0 -> done one cycle after start, in_ready never 1, out_valid never 1, tile_cnt=0.
REQ-041 Reset mid-WAIT: rst for 1 cycle at E0+3 -> out_valid stays 0, busy=0, no done; a following job with cfg_ntiles=1 completes per REQ-038.
REQ-042 Start while busy: second start pulse during WAIT -> ignored; the job finishes with the original cfg_ntiles and a single done pulse.

Source files
------------

// File: rtl/wc_tile_ctrl.sv
// wc_tile_ctrl: sequences tiles through a fixed-latency Winograd datapath.
// A job of cfg_ntiles tiles is launched by start. Each tile is accepted from
// the upstream stream, driven onto the datapath operand bus, and its result
// is captured exactly LAT cycles later. The result is then held on the
// output stream until the downstream side takes it. Only one tile is in
// flight at a time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, cfg_ntiles job launch and tile count (sampled in IDLE only)
//   in_valid/in_ready/in_data     upstream tile stream (element 0 in MSBs)
//   dp_d              registered operand bus to the datapath D port
//   dp_z              datapath result bus (Z port)
//   out_valid/out_ready/out_data/out_last  result tile stream
//   busy, done, tile_cnt          job status
module wc_tile_ctrl #(
  parameter int DW   = 10,
  parameter int NIN  = 9,
  parameter int NOUT = 5,
  parameter int LAT  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           cfg_ntiles,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*NIN-1:0]    in_data,
  output logic [DW*NIN-1:0]    dp_d,
  input  logic [DW*NOUT-1:0]   dp_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW*NOUT-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           tile_cnt
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]          ntiles_q;
  logic [7:0]          tile_cnt_q;
  logic [CW-1:0]       wcnt;
  logic [DW*NIN-1:0]   dp_d_p0;
  logic [DW*NOUT-1:0]  out_data_p1;
  logic [8:0]          cnt_inc;
  logic                accept;
  logic                capture;
  logic                hshake;
  logic                vld_p1;

  // Nine-bit increment so the "more tiles left" compare cannot wrap.
  assign cnt_inc = {1'b0, tile_cnt_q} + 9'd1;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    hshake    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cfg_ntiles != 8'd0) ? FETCH : FIN;
        end
      end
      FETCH: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // wcnt is cleared on the accept edge, so this fires on the LAT-th
        // edge after the accept.
        if (wcnt == CW'(LAT - 1)) begin
          capture   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          hshake    = 1'b1;
          state_nxt = (cnt_inc < {1'b0, ntiles_q}) ? FETCH : FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_p1    = (state == EMIT);
    in_ready  = (state == FETCH);
    out_valid = vld_p1;
    // ntiles_q is at least 1 whenever EMIT is reachable.
    out_last  = vld_p1 && (tile_cnt_q == 8'(ntiles_q - 8'd1));
    busy      = (state != IDLE);
    done      = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ntiles_q   <= 8'd0;
      tile_cnt_q <= 8'd0;
      wcnt       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        ntiles_q   <= cfg_ntiles;
        tile_cnt_q <= 8'd0;
      end
      if (accept) begin
        wcnt <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + CW'(1);
      end
      if (hshake) begin
        tile_cnt_q <= cnt_inc[7:0];
      end
    end
  end

  // Stage p0: operand register feeding the datapath D port.
  // Stage p1: result capture from the datapath Z port.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_d_p0     <= '0;
      out_data_p1 <= '0;
    end else begin
      if (accept) begin
        dp_d_p0 <= in_data;
      end
      if (capture) begin
        out_data_p1 <= dp_z;
      end
    end
  end

  assign dp_d     = dp_d_p0;
  assign out_data = out_data_p1;
  assign tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_wc_tile_ctrl.sv
// tb_wc_tile_ctrl: self-checking bench for wc_tile_ctrl. A transaction-level
// reference model tracks the job (active/in-flight/result-held/finished,
// plus the edge at which the result is due) and predicts every output after
// each clock edge. Directed sequences and a table of jobs cover the corner
// cases; random jobs and free-running random stimulus cover the rest.
module tb_wc_tile_ctrl;

  localparam int DW   = 10;
  localparam int NIN  = 9;
  localparam int NOUT = 5;
  localparam int LAT  = 6;
  localparam int IW   = DW * NIN;
  localparam int ZW   = DW * NOUT;

  logic           clk;
  logic           rst;
  logic           start;
  logic [7:0]     cfg_ntiles;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_data;
  logic [IW-1:0]  dp_d;
  logic [ZW-1:0]  dp_z;
  logic           out_valid;
  logic           out_ready;
  logic [ZW-1:0]  out_data;
  logic           out_last;
  logic           busy;
  logic           done;
  logic [7:0]     tile_cnt;

  wc_tile_ctrl #(.DW(DW), .NIN(NIN), .NOUT(NOUT), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_ntiles (cfg_ntiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dp_d       (dp_d),
    .dp_z       (dp_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .tile_cnt   (tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit z_rand = 1'b1;

  // Reference model state.
  bit            m_active, m_fin, m_inflight, m_have;
  int            m_ntiles, m_cnt, m_due;
  logic [IW-1:0] m_d;
  logic [ZW-1:0] m_res;

  // Inputs as seen just before the current edge.
  logic           p_rst, p_start, p_inv, p_ordy;
  logic [7:0]     p_cfg;
  logic [IW-1:0]  p_din;
  logic [ZW-1:0]  p_z;

  int d38 [NIN]  = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
  int z38 [NOUT] = '{160, -380, -502, 93, -120};

  typedef struct {
    int nt;
    int stall_tile;
    int stall_len;
    int restart;
    int exp_cnt;
    int exp_done;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h req=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] rnd_d();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[IW-1:0];
  endfunction

  function automatic logic [ZW-1:0] rnd_z();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[ZW-1:0];
  endfunction

  function automatic logic [IW-1:0] pack_d();
    logic [IW-1:0] v;
    v = '0;
    for (int i = 0; i < NIN; i++) v[(NIN-1-i)*DW +: DW] = DW'(d38[i]);
    return v;
  endfunction

  function automatic logic [ZW-1:0] pack_z();
    logic [ZW-1:0] v;
    v = '0;
    for (int i = 0; i < NOUT; i++) v[(NOUT-1-i)*DW +: DW] = DW'(z38[i]);
    return v;
  endfunction

  task automatic model_step();
    if (p_rst) begin
      m_active = 0; m_fin = 0; m_inflight = 0; m_have = 0;
      m_ntiles = 0; m_cnt = 0; m_due = 0; m_d = '0; m_res = '0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (p_start) begin
        m_ntiles = int'(p_cfg);
        m_cnt    = 0;
        if (m_ntiles == 0) m_fin = 1;
        else               m_active = 1;
      end
    end else if (!m_inflight) begin
      if (p_inv) begin
        m_inflight = 1;
        m_d        = p_din;
        m_due      = cyc + LAT;
      end
    end else if (!m_have) begin
      if (cyc == m_due) begin
        m_have = 1;
        m_res  = p_z;
      end
    end else if (p_ordy) begin
      m_have     = 0;
      m_inflight = 0;
      m_cnt      = (m_cnt + 1) % 256;
      if (m_cnt == m_ntiles) begin
        m_active = 0;
        m_fin    = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready",  in_ready,  m_active && !m_inflight);
    chk("out_valid", out_valid, m_have);
    chk("out_last",  out_last,  m_have && (m_cnt == m_ntiles - 1));
    chk("busy",      busy,      m_active || m_fin);
    chk("done",      done,      m_fin);
    chk("tile_cnt",  tile_cnt,  8'(m_cnt));
    chk("dp_d",      dp_d,      m_d);
    chk("out_data",  out_data,  m_res);
  endtask

  task automatic cycle();
    p_rst = rst; p_start = start; p_cfg = cfg_ntiles; p_inv = in_valid;
    p_din = in_data; p_ordy = out_ready; p_z = dp_z;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare_all();
    if (z_rand) dp_z = rnd_z();
  endtask

  task automatic run_job(input int nt, input int stall_tile, input int stall_len,
                         input int restart, output int dones);
    int  n;
    int  stall;
    int  rs;
    bit  seen;
    start = 1'b1; cfg_ntiles = 8'(nt); in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    start = 1'b0;
    dones = 0; seen = 0; n = 0; stall = stall_len; rs = restart;
    if (done) begin dones++; seen = 1; end
    while (!seen && n < nt * 40 + 50) begin
      in_valid = ($urandom % 4) != 0;
      in_data  = rnd_d();
      if (m_have && m_cnt == stall_tile && stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = ($urandom % 3) != 0;
      end
      if (rs != 0 && m_inflight && !m_have) begin
        start = 1'b1; cfg_ntiles = 8'(nt + 2); rs = 0;
      end else begin
        start = 1'b0; cfg_ntiles = 8'($urandom);
      end
      cycle();
      n++;
      if (done) begin dones++; seen = 1; end
    end
    if (!seen) chk("job_timeout", 0, 1);
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    cycle();
    if (done) dones++;
  endtask

  initial begin
    int e0;
    int dn;
    int nv;
    tbl[0] = '{nt: 1, stall_tile: -1, stall_len: 0, restart: 0, exp_cnt: 1,  exp_done: 1};
    tbl[1] = '{nt: 3, stall_tile: 1,  stall_len: 4, restart: 0, exp_cnt: 3,  exp_done: 1};
    tbl[2] = '{nt: 0, stall_tile: -1, stall_len: 0, restart: 0, exp_cnt: 0,  exp_done: 1};
    tbl[3] = '{nt: 2, stall_tile: 0,  stall_len: 0, restart: 1, exp_cnt: 2,  exp_done: 1};
    tbl[4] = '{nt: 4, stall_tile: 3,  stall_len: 2, restart: 0, exp_cnt: 4,  exp_done: 1};
    tbl[5] = '{nt: 20, stall_tile: 5, stall_len: 7, restart: 1, exp_cnt: 20, exp_done: 1};

    rst = 1'b1; start = 1'b1; cfg_ntiles = 8'd3; in_valid = 1'b1;
    out_ready = 1'b1; in_data = rnd_d(); dp_z = rnd_z();

    // Reset held two cycles with start and in_valid high.
    cycle();
    cycle();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dp_d", dp_d, '0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();

    // Single tile with fixed stub result.
    z_rand = 1'b0;
    dp_z = pack_z();
    start = 1'b1; cfg_ntiles = 8'd1;
    cycle();
    start = 1'b0; in_valid = 1'b1; in_data = pack_d();
    cycle();
    e0 = cyc;
    chk("t38_dp_d", dp_d, pack_d());
    in_valid = 1'b0; in_data = rnd_d();
    for (int k = 0; k < 20 && !out_valid; k++) cycle();
    chk("t38_ov_latency", cyc - e0, LAT);
    chk("t38_out_data", out_data, pack_z());
    chk("t38_out_last", out_last, 1'b1);
    chk("t38_dp_d_hold", dp_d, pack_d());
    out_ready = 1'b1;
    cycle();
    chk("t38_done", done, 1'b1);
    chk("t38_tile_cnt", tile_cnt, 8'd1);
    out_ready = 1'b0;
    cycle();
    chk("t38_done_end", done, 1'b0);
    chk("t38_busy_end", busy, 1'b0);
    z_rand = 1'b1;

    // Table of jobs.
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].nt, tbl[i].stall_tile, tbl[i].stall_len, tbl[i].restart, dn);
      chk("tbl_tile_cnt", tile_cnt, 8'(tbl[i].exp_cnt));
      chk("tbl_done_cnt", dn, tbl[i].exp_done);
    end

    // Reset at E0+3 during WAIT.
    start = 1'b1; cfg_ntiles = 8'd1; in_valid = 1'b0;
    cycle();
    start = 1'b0; in_valid = 1'b1; in_data = rnd_d();
    cycle();
    e0 = cyc;
    in_valid = 1'b0;
    while (cyc < e0 + 2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (out_valid || done || busy) nv++;
    end
    chk("rstwait_quiet", nv, 0);
    run_job(1, -1, 0, 0, dn);
    chk("rstwait_next_cnt", tile_cnt, 8'd1);
    chk("rstwait_next_done", dn, 1);

    // Random jobs.
    for (int i = 0; i < 20; i++) begin
      int nt;
      nt = $urandom_range(0, 6);
      run_job(nt, $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 1), dn);
      chk("rnd_tile_cnt", tile_cnt, 8'(nt));
      chk("rnd_done_cnt", dn, 1);
    end

    // Free-running random stimulus, including resets at arbitrary points.
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom % 40) == 0;
      start      = ($urandom % 6) == 0;
      cfg_ntiles = 8'($urandom % 5);
      in_valid   = ($urandom % 3) != 0;
      out_ready  = ($urandom % 3) != 0;
      in_data    = rnd_d();
      cycle();
    end
    rst = 1'b1; start = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
